// File: rtl/contadores_pkg.sv
// Shared definitions for the counter-RAM sweep logic.
package contadores_pkg;

    localparam int unsigned BITS_DIRECT_DEF  = 6;
    localparam int unsigned SIZE_COUNTER_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        CAPT = 2'd2,
        DONE = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/barrido_contadores.sv
// Sweeps the counter RAM once per start request, reporting max, argmax and sum.
// While idle, increment events pass straight through to the RAM port.
module barrido_contadores
    import contadores_pkg::*;
#(
    parameter int unsigned bitsDirect  = BITS_DIRECT_DEF,
    parameter int unsigned sizeCounter = SIZE_COUNTER_DEF
) (
    input  logic                              clk,
    input  logic                              gen_reset_n,
    input  logic                              start,
    input  logic                              clear_en,
    input  logic                              evt_valid,
    input  logic [bitsDirect-1:0]             evt_addr,
    output logic                              evt_ready,
    output logic                              write_enable,
    output logic [bitsDirect-1:0]             adress,
    output logic                              count_read,
    output logic                              count_reset,
    input  logic [sizeCounter-1:0]            count_out,
    output logic                              busy,
    output logic                              done,
    output logic [sizeCounter-1:0]            max_count,
    output logic [bitsDirect-1:0]             max_addr,
    output logic [sizeCounter+bitsDirect-1:0] total_sum
);

    localparam int unsigned SUM_W = sizeCounter + bitsDirect;
    localparam logic [bitsDirect-1:0] LAST_ADDR = {bitsDirect{1'b1}};

    sweep_state_t           state, state_nxt;
    logic [bitsDirect-1:0]  pointer, pointer_nxt;
    logic [sizeCounter-1:0] acc_max, acc_max_nxt;
    logic [bitsDirect-1:0]  acc_arg, acc_arg_nxt;
    logic [SUM_W-1:0]       acc_sum, acc_sum_nxt;
    logic                   clr_lat, clr_lat_nxt;

    // Status flags follow the state directly.
    assign busy      = (state != IDLE);
    assign evt_ready = ~busy;

    // Next-state, accumulator update and RAM command decode.
    always_comb begin
        state_nxt    = state;
        pointer_nxt  = pointer;
        acc_max_nxt  = acc_max;
        acc_arg_nxt  = acc_arg;
        acc_sum_nxt  = acc_sum;
        clr_lat_nxt  = clr_lat;
        write_enable = 1'b0;
        adress       = pointer;
        count_read   = 1'b0;
        count_reset  = 1'b0;
        case (state)
            IDLE: begin
                write_enable = evt_valid;
                adress       = evt_addr;
                if (start) begin
                    pointer_nxt = '0;
                    acc_max_nxt = '0;
                    acc_arg_nxt = '0;
                    acc_sum_nxt = '0;
                    clr_lat_nxt = clear_en;
                    state_nxt   = READ;
                end
            end
            READ: begin
                count_read = 1'b1;
                state_nxt  = CAPT;
            end
            CAPT: begin
                count_reset = clr_lat;
                acc_sum_nxt = acc_sum + SUM_W'(count_out);
                // Strict compare keeps the lowest address on ties.
                if (count_out > acc_max) begin
                    acc_max_nxt = count_out;
                    acc_arg_nxt = pointer;
                end
                if (pointer == LAST_ADDR) begin
                    state_nxt = DONE;
                end else begin
                    pointer_nxt = pointer + bitsDirect'(1);
                    state_nxt   = READ;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, sweep registers and published results.
    always_ff @(posedge clk or negedge gen_reset_n) begin
        if (!gen_reset_n) begin
            state     <= IDLE;
            pointer   <= '0;
            acc_max   <= '0;
            acc_arg   <= '0;
            acc_sum   <= '0;
            clr_lat   <= 1'b0;
            done      <= 1'b0;
            max_count <= '0;
            max_addr  <= '0;
            total_sum <= '0;
        end else begin
            state   <= state_nxt;
            pointer <= pointer_nxt;
            acc_max <= acc_max_nxt;
            acc_arg <= acc_arg_nxt;
            acc_sum <= acc_sum_nxt;
            clr_lat <= clr_lat_nxt;
            done    <= (state == DONE);
            if (state == DONE) begin
                max_count <= acc_max;
                max_addr  <= acc_arg;
                total_sum <= acc_sum;
            end
        end
    end

endmodule

// File: tb/tb_barrido_contadores.sv
// Bench for barrido_contadores with a behavioural counter RAM alongside it.
module tb_barrido_contadores;

    localparam int unsigned BD  = 6;
    localparam int unsigned SC  = 4;
    localparam int unsigned N   = 64;
    localparam int          LAT = 2 * N + 1;

    logic          clk = 1'b0;
    logic          gen_reset_n;
    logic          start;
    logic          clear_en;
    logic          evt_valid;
    logic [BD-1:0] evt_addr;
    logic          evt_ready;
    logic          write_enable;
    logic [BD-1:0] adress;
    logic          count_read;
    logic          count_reset;
    logic [SC-1:0] count_out = '0;
    logic          busy;
    logic          done;
    logic [SC-1:0] max_count;
    logic [BD-1:0] max_addr;
    logic [SC+BD-1:0] total_sum;

    logic [SC-1:0] ram     [N];
    logic [SC-1:0] preload [N];
    logic          do_preload = 1'b0;
    int            shadow  [N];
    int            n_cmp = 0;
    int            n_bad = 0;

    barrido_contadores #(.bitsDirect(BD), .sizeCounter(SC)) dut (
        .clk(clk), .gen_reset_n(gen_reset_n), .start(start), .clear_en(clear_en),
        .evt_valid(evt_valid), .evt_addr(evt_addr), .evt_ready(evt_ready),
        .write_enable(write_enable), .adress(adress), .count_read(count_read),
        .count_reset(count_reset), .count_out(count_out), .busy(busy), .done(done),
        .max_count(max_count), .max_addr(max_addr), .total_sum(total_sum)
    );

    always #5 clk = ~clk;

    // Counter RAM: increment, clear and registered read, plus bulk preload.
    always @(posedge clk) begin
        if (do_preload) begin
            for (int i = 0; i < int'(N); i++) ram[i] <= preload[i];
        end else begin
            if (write_enable) ram[adress] <= ram[adress] + 1'b1;
            if (count_reset)  ram[adress] <= '0;
            if (count_read)   count_out   <= ram[adress];
        end
    end

    task automatic load_ram();
        @(negedge clk);
        do_preload = 1'b1;
        for (int i = 0; i < int'(N); i++) shadow[i] = int'(preload[i]);
        @(negedge clk);
        do_preload = 1'b0;
    endtask

    // Expected results: max value, first index holding it, and plain sum.
    task automatic model(output int emax, output int earg, output int esum);
        emax = 0; earg = 0; esum = 0;
        foreach (shadow[i]) begin
            esum += shadow[i];
            if (shadow[i] > emax) emax = shadow[i];
        end
        for (int i = int'(N) - 1; i >= 0; i--) if (shadow[i] == emax) earg = i;
    endtask

    task automatic run_sweep(input logic clr, input bit with_evt, input logic [BD-1:0] ea,
                             input string tag);
        int emax, earg, esum, lat;
        bit got;
        @(negedge clk);
        start = 1'b1; clear_en = clr;
        if (with_evt) begin
            evt_valid = 1'b1; evt_addr = ea;
            shadow[ea] += 1;
            #1;
            n_cmp++;
            if (write_enable !== 1'b1 || adress !== ea) begin
                n_bad++;
                $display("FAIL %s start_evt: we=%b adr=%0d expected we=1 adr=%0d", tag, write_enable, adress, ea);
            end
        end
        model(emax, earg, esum);
        @(posedge clk);
        #1;
        start = 1'b0; clear_en = 1'b0; evt_valid = 1'b0;
        lat = 0; got = 1'b0;
        while (!got && lat < 300) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done === 1'b1) got = 1'b1;
        end
        n_cmp++;
        if (!got || lat != LAT) begin
            n_bad++;
            $display("FAIL %s latency: got %0d (seen=%0b) expected %0d", tag, lat, got, LAT);
        end
        n_cmp++;
        if (int'(max_count) != emax || int'(max_addr) != earg || int'(total_sum) != esum) begin
            n_bad++;
            $display("FAIL %s results: got max=%0d arg=%0d sum=%0d expected max=%0d arg=%0d sum=%0d",
                     tag, max_count, max_addr, total_sum, emax, earg, esum);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s done_width: done=%b busy=%b expected 0 0", tag, done, busy);
        end
        if (clr) foreach (shadow[i]) shadow[i] = 0;
    endtask

    task automatic test_reset();
        gen_reset_n = 1'b0; start = 1'b0; clear_en = 1'b0; evt_valid = 1'b0; evt_addr = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || max_count !== '0 || max_addr !== '0 ||
            total_sum !== '0 || evt_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b done=%b max=%0d arg=%0d sum=%0d rdy=%b expected 0 0 0 0 0 1",
                     busy, done, max_count, max_addr, total_sum, evt_ready);
        end
        gen_reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_events();
        foreach (preload[i]) preload[i] = '0;
        load_ram();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            evt_valid = 1'b1; evt_addr = BD'(5);
            shadow[5] += 1;
            #1;
            n_cmp++;
            if (write_enable !== 1'b1 || adress !== BD'(5) || evt_ready !== 1'b1 || count_read !== 1'b0) begin
                n_bad++;
                $display("FAIL event_fwd: we=%b adr=%0d rdy=%b rd=%b expected 1 5 1 0",
                         write_enable, adress, evt_ready, count_read);
            end
        end
        @(negedge clk);
        evt_valid = 1'b0;
        run_sweep(1'b0, 1'b0, '0, "events");
    endtask

    task automatic test_ties();
        foreach (preload[i]) preload[i] = SC'(1);
        preload[10] = SC'(7);
        preload[20] = SC'(7);
        load_ram();
        run_sweep(1'b0, 1'b0, '0, "ties");
    endtask

    task automatic test_clear();
        foreach (preload[i]) preload[i] = SC'($urandom_range(1, 15));
        load_ram();
        run_sweep(1'b1, 1'b0, '0, "clear_first");
        run_sweep(1'b0, 1'b0, '0, "clear_second");
    endtask

    task automatic test_full();
        foreach (preload[i]) preload[i] = SC'(15);
        load_ram();
        run_sweep(1'b0, 1'b0, '0, "full");
    endtask

    task automatic test_busy_inputs();
        int emax, earg, esum, pulses, first;
        foreach (preload[i]) preload[i] = SC'($urandom_range(0, 15));
        load_ram();
        model(emax, earg, esum);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        pulses = 0; first = 0;
        for (int c = 1; c <= LAT + 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                pulses++;
                if (first == 0) first = c;
            end
            start = 1'b0; evt_valid = 1'b0;
            if (c < LAT - 2 && (c % 7) == 3) begin
                start = 1'b1; evt_valid = 1'b1; evt_addr = BD'($urandom);
                #1;
                n_cmp++;
                if (evt_ready !== 1'b0 || write_enable !== 1'b0 || busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL busy_block c=%0d: rdy=%b we=%b busy=%b expected 0 0 1",
                             c, evt_ready, write_enable, busy);
                end
            end
        end
        n_cmp++;
        if (pulses != 1 || first != LAT) begin
            n_bad++;
            $display("FAIL busy_done: pulses=%0d at=%0d expected 1 at %0d", pulses, first, LAT);
        end
        n_cmp++;
        if (int'(max_count) != emax || int'(max_addr) != earg || int'(total_sum) != esum) begin
            n_bad++;
            $display("FAIL busy_results: got %0d/%0d/%0d expected %0d/%0d/%0d",
                     max_count, max_addr, total_sum, emax, earg, esum);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        foreach (preload[i]) preload[i] = SC'($urandom_range(0, 12));
        load_ram();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(negedge clk);
        gen_reset_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || max_count !== '0 || max_addr !== '0 || total_sum !== '0 ||
            count_read !== 1'b0 || count_reset !== 1'b0 || write_enable !== 1'b0 || evt_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid: busy=%b done=%b max=%0d arg=%0d sum=%0d rd=%b clr=%b we=%b rdy=%b",
                     busy, done, max_count, max_addr, total_sum, count_read, count_reset, write_enable, evt_ready);
        end
        @(negedge clk);
        gen_reset_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < LAT + 20; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL reset_abandon: active cycles=%0d expected 0", pulses);
        end
        run_sweep(1'b0, 1'b0, '0, "after_reset");
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            logic [BD-1:0] a;
            int nev;
            foreach (preload[i]) preload[i] = SC'($urandom_range(0, 12));
            load_ram();
            nev = $urandom_range(1, 6);
            for (int k = 0; k < nev; k++) begin
                @(negedge clk);
                a = BD'($urandom);
                evt_valid = 1'b1; evt_addr = a;
                shadow[a] += 1;
                #1;
                n_cmp++;
                if (write_enable !== 1'b1 || adress !== a) begin
                    n_bad++;
                    $display("FAIL rand_evt: we=%b adr=%0d expected 1 %0d", write_enable, adress, a);
                end
            end
            @(negedge clk);
            evt_valid = 1'b0;
            a = BD'($urandom);
            run_sweep(logic'($urandom_range(0, 1)), 1'b1, a, "random");
        end
    endtask

    initial begin
        test_reset();
        test_events();
        test_ties();
        test_clear();
        test_full();
        test_busy_inputs();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/barrido_contadores.md
BARRIDO_CONTADORES -- requirements
Module: barrido_contadores

Interface
REQ-001 Parameter bitsDirect, default 6: counter-RAM address width; 2**bitsDirect entries.
REQ-002 Parameter sizeCounter, default 4: counter-RAM entry width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 gen_reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request one full sweep of the counter RAM.
REQ-006 clear_en  in  1  zero each entry after reading it; sampled with start.
REQ-007 evt_valid  in  1  increment request for entry evt_addr.
REQ-008 evt_addr  in  bitsDirect  entry to increment.
REQ-009 evt_ready  out  1  event accepted this cycle when evt_valid is also 1.
REQ-010 write_enable  out  1  increment command to the counter RAM.
REQ-011 adress  out  bitsDirect  counter-RAM address.
REQ-012 count_read  out  1  read command to the counter RAM.
REQ-013 count_reset  out  1  clear command to the counter RAM.
REQ-014 count_out  in  sizeCounter  registered read data from the counter RAM.
REQ-015 busy  out  1  sweep in progress.
REQ-016 done  out  1  one-cycle pulse; results valid.
REQ-017 max_count  out  sizeCounter  largest entry seen in the last sweep.
REQ-018 max_addr  out  bitsDirect  address of max_count.
REQ-019 total_sum  out  sizeCounter+bitsDirect  sum of all entries in the last sweep.

Function
REQ-020 States: IDLE, READ, CAPT, DONE.
REQ-021 busy = (state != IDLE); evt_ready = ~busy.
REQ-022 In IDLE, RAM outputs are combinational: write_enable = evt_valid, adress = evt_addr, count_read = 0, count_reset = 0.
REQ-023 IDLE with start=1 at an edge: pointer <= 0, sweep accumulators <= 0, latch clear_en, go to READ.
REQ-024 An event presented in the same IDLE cycle as start is still forwarded.
REQ-025 start while busy is ignored.
REQ-026 READ drives the following, then goes to CAPT:
- adress = pointer
- count_read = 1
- write_enable = 0
- count_reset = 0
REQ-027 CAPT drives adress = pointer, count_read = 0, write_enable = 0, and count_reset = latched clear_en.
REQ-028 CAPT samples count_out, which is the value read at the READ edge.
REQ-029 CAPT updates accumulators as follows:
- sum += count_out, zero-extended
- if count_out > max, then max <= count_out and argmax <= pointer (strictly greater, so the lowest address wins ties)
REQ-030 CAPT exit: if pointer == 2**bitsDirect-1, go to DONE; else pointer += 1 and go to READ.
REQ-031 DONE, one cycle:
- done = 1
- max_count, max_addr and total_sum load from the accumulators
- next state IDLE
REQ-032 max_count, max_addr and total_sum hold until the next DONE.
REQ-033 Latency from the start edge to the done pulse is 2*2**bitsDirect+1 cycles (129 at default parameters).
REQ-034 total_sum cannot overflow: the maximum is (2**sizeCounter-1)*2**bitsDirect.
REQ-035 An all-zero RAM yields max_count = 0, max_addr = 0, total_sum = 0.
REQ-036 Events offered during a sweep are not accepted (evt_ready = 0); the upstream block holds them.

Reset
REQ-037 gen_reset_n = 0 immediately forces IDLE, and sets pointer, accumulators, max_count, max_addr, total_sum, done and busy to 0.
REQ-038 A reset mid-sweep abandons the sweep with no done pulse; this block does not clear RAM contents.

Structure
REQ-039 A shared package contadores_pkg holds the sweep-state enum typedef and the default bitsDirect/sizeCounter constants.
REQ-040 No sub-module; the block instantiates alongside ContadoresRAM at the same level.
REQ-041 The sweep pointer is the only counter; the next-state logic is a single combinational block.

Verification
REQ-042 Reset, then evt_valid=1 with evt_addr=5 for 3 cycles -> write_enable=1 and adress=5 for 3 cycles; a later sweep gives max_count=3, max_addr=5, total_sum=3.
REQ-043 Entries 10 and 20 both at 7, all others at 1, start -> done at cycle 129; max_count=7, max_addr=10, total_sum=76.
REQ-044 clear_en=1 sweep over nonzero entries, then a second sweep -> second result is max_count=0, max_addr=0, total_sum=0.
REQ-045 All 64 entries at 15 -> total_sum=960, max_addr=0.
REQ-046 start and evt_valid asserted during a sweep -> evt_ready=0, write_enable=0, no restart, exactly one done pulse.
REQ-047 gen_reset_n pulsed low at cycle 40 of a sweep -> state IDLE, outputs 0, no done pulse; the next start runs a full 129-cycle sweep.
